// File: rtl/shift_cmd_sequencer_if.sv
// Command and shifter-control bundle for shift_cmd_sequencer.
// The exp shadow-register port exists only when SHIFT_SHADOW_EN is defined.
interface shift_cmd_sequencer_if #(
  parameter int DEPTH = 4
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_amt;
  logic [7:0]       cmd_data;
  logic [1:0]       cmd_rep;
  logic [1:0]       c;
  logic [2:0]       s;
  logic [7:0]       i;
  logic             busy;
  logic             done;
  logic [LVL_W-1:0] level;
`ifdef SHIFT_SHADOW_EN
  logic [7:0]       exp;
`endif

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_rep,
`ifdef SHIFT_SHADOW_EN
    input  exp,
`endif
    input  cmd_ready, c, s, i, busy, done, level
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_rep,
`ifdef SHIFT_SHADOW_EN
    output exp,
`endif
    output cmd_ready, c, s, i, busy, done, level
  );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO plus drive/gap sequencer feeding the 8-bit barrel shifter's c/s/i.
// Optional shifter shadow register (exp output) enabled by defining SHIFT_SHADOW_EN.
module shift_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 1
) (
  input logic                  clk,
  input logic                  rst,
  shift_cmd_sequencer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [1:0] rep;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_t           state;
  logic [1:0]       cur_op;
  logic [2:0]       cur_amt;
  logic [7:0]       cur_data;
  logic [1:0]       rcnt;
  logic [GAP_W-1:0] gcnt;
  logic [1:0]       c_r;
  logic [2:0]       s_r;
  logic [7:0]       i_r;
  logic             done_r;

  assign full  = (count == LVL_W'(DEPTH));
  assign empty = (count == '0);
  // Ready depends only on occupancy, so a pop on the same edge never frees a full FIFO.
  assign push  = bus.cmd_valid && !full;
  assign pop   = (state == IDLE) && !empty;

  function automatic logic [7:0] drive_data(logic [1:0] op, logic [7:0] data);
    return (op == OP_LOAD) ? data : 8'h00;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {bus.cmd_op, bus.cmd_amt, bus.cmd_data, bus.cmd_rep};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are registered one state behind: the DRIVE state loads c/s/i, and the
  // GAP state's final edge either re-drives (repeat) or raises done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rcnt   <= '0;
      gcnt   <= '0;
      c_r    <= 2'b00;
      s_r    <= '0;
      i_r    <= '0;
      done_r <= 1'b0;
    end else begin
      c_r    <= 2'b00;
      s_r    <= '0;
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            cur_op   <= mem[rptr].op;
            cur_amt  <= mem[rptr].amt;
            cur_data <= mem[rptr].data;
            rcnt     <= mem[rptr].rep;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          c_r   <= cur_op;
          s_r   <= cur_amt;
          i_r   <= drive_data(cur_op, cur_data);
          gcnt  <= GAP_W'(GAP_CYC);
          state <= GAP;
        end
        GAP: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - 1'b1;
          end else if (rcnt != '0) begin
            rcnt <= rcnt - 1'b1;
            c_r  <= cur_op;
            s_r  <= cur_amt;
            i_r  <= drive_data(cur_op, cur_data);
            gcnt <= GAP_W'(GAP_CYC);
          end else begin
            done_r <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_SHADOW_EN
  logic [7:0] exp_r;

  function automatic logic [7:0] shadow_next(logic [7:0] cur_v, logic [1:0] op,
                                             logic [2:0] amt, logic [7:0] data);
    logic [7:0] nxt;
    case (op)
      2'b11:   nxt = data;
      2'b01:   nxt = cur_v << amt;
      2'b10:   nxt = cur_v >> amt;
      default: nxt = cur_v;
    endcase
    return nxt;
  endfunction

  // c is non-zero only in a drive cycle, so this tracks the shifter at the end of each drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_r <= 8'h00;
    end else if (c_r != 2'b00) begin
      exp_r <= shadow_next(exp_r, c_r, s_r, i_r);
    end
  end

  assign bus.exp = exp_r;
`endif

  assign bus.cmd_ready = !full;
  assign bus.c         = c_r;
  assign bus.s         = s_r;
  assign bus.i         = i_r;
  assign bus.done      = done_r;
  assign bus.level     = count;
  assign bus.busy      = (state != IDLE) || !empty;
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Self-checking bench for shift_cmd_sequencer: a command-expansion reference model
// predicts every output cycle; scenario tasks add targeted checks.
module tb_shift_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 1;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int VW    = 16 + LVL_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();
  shift_cmd_sequencer #(.DEPTH(DEPTH), .GAP_CYC(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {int op; int amt; int data; int rep;} mcmd_t;
  typedef struct {bit active; bit drive; bit done; int c; int s; int i;} slot_t;

  mcmd_t mq[$];
  slot_t sched[$];
  int m_c, m_s, m_i, m_exp, m_level;
  bit m_done, m_busy, m_ready, m_active, m_drive;

  function automatic int apply_shadow(int e, int op, int amt, int d);
    case (op)
      3:       return d;
      1:       return (e * (2 ** amt)) % 256;
      2:       return e / (2 ** amt);
      default: return e;
    endcase
  endfunction

  // Each popped command expands into its full per-cycle output schedule.
  always @(posedge clk) begin
    mcmd_t nc;
    slot_t sl;
    bit take;
    if (rst) begin
      mq.delete(); sched.delete();
      m_c = 0; m_s = 0; m_i = 0; m_exp = 0; m_level = 0;
      m_done = 0; m_busy = 0; m_ready = 1; m_active = 0; m_drive = 0;
    end else begin
      if (m_drive) m_exp = apply_shadow(m_exp, m_c, m_s, m_i);
      take = bus.cmd_valid && (mq.size() < DEPTH);
      if (sched.size() == 0 && mq.size() != 0) begin
        nc = mq.pop_front();
        sched.push_back('{1'b1, 1'b0, 1'b0, 0, 0, 0});
        for (int r = 0; r <= nc.rep; r++) begin
          sched.push_back('{1'b1, 1'b1, 1'b0, nc.op, nc.amt, (nc.op == 3) ? nc.data : 0});
          for (int g = 0; g < GAP; g++) sched.push_back('{1'b1, 1'b0, 1'b0, 0, 0, 0});
        end
        sched.push_back('{1'b0, 1'b0, 1'b1, 0, 0, 0});
      end
      if (take) mq.push_back('{int'(bus.cmd_op), int'(bus.cmd_amt), int'(bus.cmd_data), int'(bus.cmd_rep)});
      if (sched.size() != 0) sl = sched.pop_front();
      else sl = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
      m_c = sl.c; m_s = sl.s; m_done = sl.done; m_active = sl.active; m_drive = sl.drive;
      if (sl.drive) m_i = sl.i;
      m_level = mq.size();
      m_busy  = m_active || (m_level != 0);
      m_ready = (m_level < DEPTH);
    end
  end

  function automatic logic [VW-1:0] dut_vec();
    return {bus.c, bus.s, bus.i, bus.done, bus.busy, bus.cmd_ready, bus.level};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {2'(m_c), 3'(m_s), 8'(m_i), m_done, m_busy, m_ready, LVL_W'(m_level)};
  endfunction

  function automatic int key(int op, int amt, int data);
    return op * 2048 + amt * 256 + ((op == 3) ? data : 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(bit v, int op, int amt, int data, int rep);
    bus.cmd_valid = v;
    bus.cmd_op    = 2'(op);
    bus.cmd_amt   = 3'(amt);
    bus.cmd_data  = 8'(data);
    bus.cmd_rep   = 2'(rep);
  endtask

  task automatic test_reset();
    logic [VW-1:0] want;
    rst = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
    tick();
    tick();
    want = {2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, LVL_W'(0)};
    checks++;
    if (dut_vec() !== want) begin
      failures++;
      $display("FAIL reset_state got=%h want=%h", dut_vec(), want);
    end
`ifdef SHIFT_SHADOW_EN
    checks++;
    if (bus.exp !== 8'h00) begin
      failures++;
      $display("FAIL reset_exp got=%h want=00", bus.exp);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_load();
    int first_drive, done_at, drives, dones;
    first_drive = -1; done_at = -1; drives = 0; dones = 0;
    set_cmd(1, 3, 0, 8'hA5, 0);
    tick();
    set_cmd(0, 0, 0, 0, 0);
    for (int n = 0; n < 12; n++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL load_trace n=%0d got=%h want=%h", n, dut_vec(), mdl_vec());
      end
      if (bus.c == 2'b11) begin
        drives++;
        if (first_drive < 0) first_drive = n;
        checks++;
        if (bus.i !== 8'hA5) begin
          failures++;
          $display("FAIL load_i got=%h want=a5", bus.i);
        end
      end
      if (bus.done) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
      tick();
    end
    checks++;
    if (first_drive !== 2 || drives !== 1) begin
      failures++;
      $display("FAIL load_latency first=%0d drives=%0d want first=2 drives=1", first_drive, drives);
    end
    checks++;
    if (done_at !== 3 + GAP || dones !== 1) begin
      failures++;
      $display("FAIL load_done at=%0d count=%0d want at=%0d count=1", done_at, dones, 3 + GAP);
    end
`ifdef SHIFT_SHADOW_EN
    checks++;
    if (bus.exp !== 8'hA5) begin
      failures++;
      $display("FAIL load_exp got=%h want=a5", bus.exp);
    end
`endif
  endtask

  task automatic test_repeat();
    int drv_idx[$];
    logic [7:0] exps[$];
    bit prev_shift;
    int bad_sep;
    prev_shift = 0; bad_sep = 0;
    set_cmd(1, 3, 0, 8'h01, 0);
    tick();
    set_cmd(1, 1, 3, $urandom_range(0, 255), 2);
    tick();
    set_cmd(0, 0, 0, 0, 0);
    for (int n = 0; n < 25; n++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL repeat_trace n=%0d got=%h want=%h", n, dut_vec(), mdl_vec());
      end
`ifdef SHIFT_SHADOW_EN
      if (prev_shift) exps.push_back(bus.exp);
`endif
      prev_shift = (bus.c == 2'b01);
      if (bus.c == 2'b01) begin
        if (bus.s !== 3'd3 || bus.i !== 8'h00) bad_sep++;
        drv_idx.push_back(n);
      end
      tick();
    end
    for (int k = 1; k < drv_idx.size(); k++)
      if (drv_idx[k] - drv_idx[k-1] != GAP + 1) bad_sep++;
    checks++;
    if (drv_idx.size() != 3 || bad_sep != 0) begin
      failures++;
      $display("FAIL repeat_drives count=%0d bad=%0d want count=3 bad=0", drv_idx.size(), bad_sep);
    end
`ifdef SHIFT_SHADOW_EN
    checks++;
    if (exps.size() != 3 || exps[0] !== 8'h08 || exps[1] !== 8'h40 || exps[2] !== 8'h00) begin
      failures++;
      $display("FAIL repeat_exp got n=%0d want 08 40 00", exps.size());
    end
`endif
  endtask

  task automatic test_full();
    int ops[6], amts[6], datas[6], reps[6];
    int want[$];
    int got[$];
    int idx;
    bit acc, saw_full;
    ops[0] = 0; amts[0] = 0; datas[0] = 0; reps[0] = 3;
    for (int k = 1; k < 6; k++) begin
      ops[k] = $urandom_range(1, 3); amts[k] = $urandom_range(0, 7);
      datas[k] = $urandom_range(0, 255); reps[k] = 0;
      want.push_back(key(ops[k], amts[k], datas[k]));
    end
    idx = 0; saw_full = 0;
    for (int n = 0; n < 80; n++) begin
      if (idx < 6) set_cmd(1, ops[idx], amts[idx], datas[idx], reps[idx]);
      else set_cmd(0, 0, 0, 0, 0);
      acc = (idx < 6) && bus.cmd_ready;
      if (bus.level == LVL_W'(DEPTH)) begin
        saw_full = 1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_ready n=%0d got=%b want=0", n, bus.cmd_ready);
        end
      end
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL full_trace n=%0d got=%h want=%h", n, dut_vec(), mdl_vec());
      end
      if (bus.c != 2'b00) got.push_back(int'({bus.c, bus.s, bus.i}));
      tick();
      if (acc) idx++;
    end
    set_cmd(0, 0, 0, 0, 0);
    checks++;
    if (!saw_full) begin
      failures++;
      $display("FAIL full_reached got=0 want=1");
    end
    checks++;
    if (got.size() != want.size()) begin
      failures++;
      $display("FAIL full_order_count got=%0d want=%0d", got.size(), want.size());
    end else begin
      for (int k = 0; k < want.size(); k++) begin
        checks++;
        if (got[k] != want[k]) begin
          failures++;
          $display("FAIL full_order k=%0d got=%h want=%h", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, stray_drv, stray_done;
    stray_drv = 0; stray_done = 0;
    set_cmd(1, 1, 1, 0, 3);
    tick();
    set_cmd(0, 0, 0, 0, 0);
    for (n = 0; n < 10 && bus.c == 2'b00; n++) tick();
    checks++;
    if (bus.c !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_wait got c=%b want 01 within 10 cycles", bus.c);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.c !== 2'b00 || bus.level !== LVL_W'(0) || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_state got c=%b level=%0d busy=%b want 00 0 0", bus.c, bus.level, bus.busy);
    end
    for (int k = 0; k < 20; k++) begin
      if (bus.c != 2'b00) stray_drv++;
      if (bus.done) stray_done++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL rstmid_trace k=%0d got=%h want=%h", k, dut_vec(), mdl_vec());
      end
      tick();
    end
    checks++;
    if (stray_drv != 0 || stray_done != 0) begin
      failures++;
      $display("FAIL rstmid_quiet drives=%0d dones=%0d want 0 0", stray_drv, stray_done);
    end
  endtask

  task automatic test_push_pop();
    int ops[3], amts[3], datas[3];
    int want[$];
    int got[$];
    int n;
    for (int k = 0; k < 3; k++) begin
      ops[k] = $urandom_range(1, 3); amts[k] = $urandom_range(0, 7); datas[k] = $urandom_range(0, 255);
      want.push_back(key(ops[k], amts[k], datas[k]));
    end
    set_cmd(1, 0, 0, 0, 1);
    tick();
    set_cmd(1, ops[0], amts[0], datas[0], 0);
    tick();
    set_cmd(1, ops[1], amts[1], datas[1], 0);
    tick();
    set_cmd(0, 0, 0, 0, 0);
    for (n = 0; n < 30 && !bus.done; n++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.level !== LVL_W'(2)) begin
      failures++;
      $display("FAIL pushpop_pre done=%b level=%0d want 1 2", bus.done, bus.level);
    end
    set_cmd(1, ops[2], amts[2], datas[2], 0);
    tick();
    set_cmd(0, 0, 0, 0, 0);
    checks++;
    if (bus.level !== LVL_W'(2) || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pushpop_level got level=%0d busy=%b want 2 1", bus.level, bus.busy);
    end
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL pushpop_trace k=%0d got=%h want=%h", k, dut_vec(), mdl_vec());
      end
      if (bus.c != 2'b00) got.push_back(int'({bus.c, bus.s, bus.i}));
      tick();
    end
    checks++;
    if (got.size() != 3 || got[0] != want[0] || got[1] != want[1] || got[2] != want[2]) begin
      failures++;
      $display("FAIL pushpop_order count=%0d want 3 in push order", got.size());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 440; n++) begin
      if (n < 400) set_cmd($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 7),
                           $urandom_range(0, 255), $urandom_range(0, 3));
      else set_cmd(0, 0, 0, 0, 0);
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random_trace n=%0d got=%h want=%h", n, dut_vec(), mdl_vec());
      end
`ifdef SHIFT_SHADOW_EN
      checks++;
      if (bus.exp !== 8'(m_exp)) begin
        failures++;
        $display("FAIL random_exp n=%0d got=%h want=%h", n, bus.exp, 8'(m_exp));
      end
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_repeat();
    test_full();
    test_reset_mid();
    test_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
